freq_cmd_parser: RTL and testbench

FREQ_CMD_PARSER -- requirements
Module: freq_cmd_parser

---
 rtl/freq_cmd_parser_pkg.sv | 36 +++
 rtl/freq_cmd_parser_byte_timeout.sv | 33 +++
 rtl/freq_cmd_parser.sv | 155 +++++++++++++++
 tb/tb_freq_cmd_parser.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_cmd_parser_pkg.sv
// Shared constants, FSM states and reply payload type for the UART frequency
// command parser.
package freq_cmd_parser_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned PAYLOAD_W  = 64;
  localparam int unsigned DECIM_W    = 16;
  localparam int unsigned DATA_BYTES = 8;
  localparam int unsigned BCNT_W     = 3;

  localparam logic [BYTE_W-1:0] SYNC_BYTE     = 8'hA5;
  localparam logic [BYTE_W-1:0] CMD_SET_PHASE = 8'h01;
  localparam logic [BYTE_W-1:0] CMD_SET_DECIM = 8'h02;
  localparam logic [BYTE_W-1:0] ACK           = 8'h06;
  localparam logic [BYTE_W-1:0] NAK           = 8'h15;

  localparam logic [DECIM_W-1:0] MIN_DECIM = 16'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2,
    ST_CHK  = 2'd3
  } parser_state_t;

  typedef struct packed {
    logic              valid;
    logic [BYTE_W-1:0] code;
  } reply_t;

  // Decimation ratios below 2 would stall the CIC, so they are rejected.
  function automatic logic decim_ok(input logic [PAYLOAD_W-1:0] payload);
    return payload[DECIM_W-1:0] >= MIN_DECIM;
  endfunction

endpackage

// File: rtl/freq_cmd_parser_byte_timeout.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and flags
// expiry once TIMEOUT_CLKS cycles have elapsed.
module byte_timeout #(
  parameter int unsigned TIMEOUT_CLKS = 34650
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CLKS + 2);

  logic [CNT_W-1:0] cnt_q;

  // Saturates at the limit so a stalled enable can never wrap and re-fire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      expired <= 1'b0;
    end else if (clear || !enable) begin
      cnt_q   <= '0;
      expired <= 1'b0;
    end else begin
      if (cnt_q != CNT_W'(TIMEOUT_CLKS)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      expired <= (cnt_q == CNT_W'(TIMEOUT_CLKS - 1));
    end
  end

endmodule

// File: rtl/freq_cmd_parser.sv
// Parses sync/cmd/payload/checksum frames from the UART receiver, updates the
// NCO tuning word or CIC decimation ratio and returns an ACK/NAK byte.
module freq_cmd_parser
  import freq_cmd_parser_pkg::*;
#(
  parameter int unsigned      TIMEOUT_CLKS      = 34650,
  parameter logic [63:0]      DEFAULT_PHASE_INC = 64'h1B1B4294E949F45,
  parameter logic [15:0]      DEFAULT_DECIM     = 16'd4096
) (
  input  logic                 osc_clk,
  input  logic                 rst,
  input  logic                 i_Rx_DV,
  input  logic [BYTE_W-1:0]    i_Rx_Byte,
  input  logic                 i_Tx_Active,
  output logic [PAYLOAD_W-1:0] phase_inc_carr,
  output logic [DECIM_W-1:0]   decimation_ratio,
  output logic                 o_update,
  output logic                 o_frame_err,
  output logic                 o_Tx_DV,
  output logic [BYTE_W-1:0]    o_Tx_Byte
);

  parser_state_t        state_q, state_d;
  logic [BYTE_W-1:0]    cmd_q, cmd_d;
  logic [BYTE_W-1:0]    xor_q, xor_d;
  logic [BCNT_W-1:0]    bcnt_q, bcnt_d;
  logic [PAYLOAD_W-1:0] payload_q, payload_d;
  logic [PAYLOAD_W-1:0] phase_d;
  logic [DECIM_W-1:0]   decim_d;
  logic                 update_d;
  logic                 frame_err_d;
  logic                 tx_dv_d;
  logic [BYTE_W-1:0]    tx_byte_d;
  reply_t               slot_q, slot_d;
  reply_t               reply;
  parser_state_t        eff_state;
  logic                 expired;

  byte_timeout #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_byte_timeout (
    .clk    (osc_clk),
    .rst    (rst),
    .clear  (i_Rx_DV),
    .enable (state_q != ST_IDLE),
    .expired(expired)
  );

  always_ff @(posedge osc_clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      cmd_q            <= '0;
      xor_q            <= '0;
      bcnt_q           <= '0;
      payload_q        <= '0;
      slot_q           <= '0;
      phase_inc_carr   <= DEFAULT_PHASE_INC;
      decimation_ratio <= DEFAULT_DECIM;
      o_update         <= 1'b0;
      o_frame_err      <= 1'b0;
      o_Tx_DV          <= 1'b0;
      o_Tx_Byte        <= '0;
    end else begin
      state_q          <= state_d;
      cmd_q            <= cmd_d;
      xor_q            <= xor_d;
      bcnt_q           <= bcnt_d;
      payload_q        <= payload_d;
      slot_q           <= slot_d;
      phase_inc_carr   <= phase_d;
      decimation_ratio <= decim_d;
      o_update         <= update_d;
      o_frame_err      <= frame_err_d;
      o_Tx_DV          <= tx_dv_d;
      o_Tx_Byte        <= tx_byte_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    xor_d       = xor_q;
    bcnt_d      = bcnt_q;
    payload_d   = payload_q;
    phase_d     = phase_inc_carr;
    decim_d     = decimation_ratio;
    update_d    = 1'b0;
    frame_err_d = 1'b0;
    tx_dv_d     = 1'b0;
    tx_byte_d   = o_Tx_Byte;
    slot_d      = slot_q;
    reply       = '0;

    // A timeout wins over a coincident byte, which is then parsed as if idle.
    eff_state = state_q;
    if (expired) begin
      eff_state   = ST_IDLE;
      state_d     = ST_IDLE;
      frame_err_d = 1'b1;
    end

    if (i_Rx_DV) begin
      case (eff_state)
        ST_IDLE: begin
          if (i_Rx_Byte == SYNC_BYTE) begin
            state_d = ST_CMD;
          end
        end
        ST_CMD: begin
          cmd_d   = i_Rx_Byte;
          xor_d   = i_Rx_Byte;
          bcnt_d  = '0;
          state_d = ST_DATA;
        end
        ST_DATA: begin
          payload_d = {payload_q[PAYLOAD_W-BYTE_W-1:0], i_Rx_Byte};
          xor_d     = xor_q ^ i_Rx_Byte;
          bcnt_d    = bcnt_q + BCNT_W'(1);
          if (bcnt_q == BCNT_W'(DATA_BYTES - 1)) begin
            state_d = ST_CHK;
          end
        end
        ST_CHK: begin
          state_d     = ST_IDLE;
          reply.valid = 1'b1;
          if ((xor_q == i_Rx_Byte) && (cmd_q == CMD_SET_PHASE)) begin
            phase_d    = payload_q;
            update_d   = 1'b1;
            reply.code = ACK;
          end else if ((xor_q == i_Rx_Byte) && (cmd_q == CMD_SET_DECIM) &&
                       decim_ok(payload_q)) begin
            decim_d    = payload_q[DECIM_W-1:0];
            update_d   = 1'b1;
            reply.code = ACK;
          end else begin
            frame_err_d = 1'b1;
            reply.code  = NAK;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Drain the reply slot when the transmitter is free; a fresh reply overwrites.
    if (slot_q.valid && !i_Tx_Active) begin
      tx_dv_d      = 1'b1;
      tx_byte_d    = slot_q.code;
      slot_d.valid = 1'b0;
    end
    if (reply.valid) begin
      slot_d = reply;
    end
  end

endmodule

// File: tb/tb_freq_cmd_parser.sv
// Self-checking bench for freq_cmd_parser: directed vectors plus randomized
// frames scored against a frame-level reference model.
module tb_freq_cmd_parser;

  localparam int unsigned T       = 40;
  localparam logic [63:0] DEF_PH  = 64'h1B1B4294E949F45;
  localparam logic [15:0] DEF_DEC = 16'd4096;

  logic        osc_clk = 1'b0;
  logic        rst;
  logic        i_Rx_DV;
  logic [7:0]  i_Rx_Byte;
  logic        i_Tx_Active;
  logic [63:0] phase_inc_carr;
  logic [15:0] decimation_ratio;
  logic        o_update;
  logic        o_frame_err;
  logic        o_Tx_DV;
  logic [7:0]  o_Tx_Byte;

  freq_cmd_parser #(
    .TIMEOUT_CLKS     (T),
    .DEFAULT_PHASE_INC(DEF_PH),
    .DEFAULT_DECIM    (DEF_DEC)
  ) dut (
    .osc_clk         (osc_clk),
    .rst             (rst),
    .i_Rx_DV         (i_Rx_DV),
    .i_Rx_Byte       (i_Rx_Byte),
    .i_Tx_Active     (i_Tx_Active),
    .phase_inc_carr  (phase_inc_carr),
    .decimation_ratio(decimation_ratio),
    .o_update        (o_update),
    .o_frame_err     (o_frame_err),
    .o_Tx_DV         (o_Tx_DV),
    .o_Tx_Byte       (o_Tx_Byte)
  );

  always #5 osc_clk = ~osc_clk;

  int          checks = 0;
  int          errors = 0;
  int          upd_cnt = 0;
  int          err_cnt = 0;
  logic [7:0]  tx_q[$];
  logic [63:0] exp_phase;
  logic [15:0] exp_decim;
  logic [7:0]  frm[11];

  always @(negedge osc_clk) begin
    if (!rst) begin
      if (o_update) upd_cnt++;
      if (o_frame_err) err_cnt++;
      if (o_Tx_DV) tx_q.push_back(o_Tx_Byte);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge osc_clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    i_Rx_DV   = 1'b1;
    i_Rx_Byte = b;
    cyc(1);
    i_Rx_DV   = 1'b0;
    cyc(gap);
  endtask

  task automatic make_frame(input logic [7:0] cmd, input logic [63:0] payload,
                            input logic [7:0] chk_flip);
    logic [7:0] x;
    frm[0] = 8'hA5;
    frm[1] = cmd;
    x      = cmd;
    for (int i = 0; i < 8; i++) begin
      frm[2+i] = payload[63-8*i -: 8];
      x        = x ^ frm[2+i];
    end
    frm[10] = x ^ chk_flip;
  endtask

  task automatic send_frame(input int max_gap);
    for (int i = 0; i < 11; i++) send_byte(frm[i], int'($urandom_range(max_gap, 0)));
  endtask

  // Frame-level reference: decide accept/reject from the bytes and update expectations.
  task automatic model_frame(output bit acc);
    logic [7:0]  x;
    logic [63:0] pl;
    x  = 8'h00;
    pl = '0;
    for (int i = 1; i <= 9; i++) x = x ^ frm[i];
    for (int i = 2; i <= 9; i++) pl = (pl << 8) | 64'(frm[i]);
    acc = 1'b0;
    if (x == frm[10] && frm[1] == 8'h01) begin
      exp_phase = pl;
      acc = 1'b1;
    end else if (x == frm[10] && frm[1] == 8'h02 && pl[15:0] >= 16'd2) begin
      exp_decim = pl[15:0];
      acc = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(3);
    checks++; if (phase_inc_carr !== DEF_PH) begin errors++; $display("FAIL reset_phase got %h exp %h", phase_inc_carr, DEF_PH); end
    checks++; if (decimation_ratio !== DEF_DEC) begin errors++; $display("FAIL reset_decim got %h exp %h", decimation_ratio, DEF_DEC); end
    checks++; if (o_update !== 1'b0) begin errors++; $display("FAIL reset_update got %b exp 0", o_update); end
    checks++; if (o_frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b exp 0", o_frame_err); end
    checks++; if (o_Tx_DV !== 1'b0) begin errors++; $display("FAIL reset_tx_dv got %b exp 0", o_Tx_DV); end
    checks++; if (o_Tx_Byte !== 8'h00) begin errors++; $display("FAIL reset_tx_byte got %h exp 00", o_Tx_Byte); end
    rst = 1'b0;
    exp_phase = DEF_PH;
    exp_decim = DEF_DEC;
    cyc(2);
  endtask

  task automatic test_bad_chk();
    int u0, e0;
    u0 = upd_cnt; e0 = err_cnt; tx_q.delete();
    make_frame(8'h01, 64'h10, 8'hFF);
    send_frame(2);
    cyc(6);
    checks++; if (phase_inc_carr !== DEF_PH) begin errors++; $display("FAIL bad_chk_phase got %h exp %h", phase_inc_carr, DEF_PH); end
    checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL bad_chk_err got %0d exp 1", err_cnt - e0); end
    checks++; if (upd_cnt - u0 !== 0) begin errors++; $display("FAIL bad_chk_update got %0d exp 0", upd_cnt - u0); end
    checks++; if (tx_q.size() != 1 || tx_q[0] !== 8'h15) begin errors++; $display("FAIL bad_chk_reply got n=%0d first=%h exp 15", tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'hxx); end
  endtask

  task automatic test_vectors();
    int u0, e0;
    // Phase frame A5 01 00x7 10 11.
    u0 = upd_cnt; tx_q.delete();
    make_frame(8'h01, 64'h10, 8'h00);
    checks++; if (frm[10] !== 8'h11) begin errors++; $display("FAIL vec_phase_chk got %h exp 11", frm[10]); end
    send_frame(0);
    cyc(6);
    checks++; if (phase_inc_carr !== 64'h10) begin errors++; $display("FAIL vec_phase got %h exp 10", phase_inc_carr); end
    checks++; if (upd_cnt - u0 !== 1) begin errors++; $display("FAIL vec_phase_update got %0d exp 1", upd_cnt - u0); end
    checks++; if (tx_q.size() != 1 || tx_q[0] !== 8'h06) begin errors++; $display("FAIL vec_phase_reply got n=%0d exp one 06", tx_q.size()); end
    // Decimation 2048 accepted, then ratio 1 rejected.
    tx_q.delete();
    make_frame(8'h02, 64'h0800, 8'h00);
    send_frame(1);
    cyc(6);
    checks++; if (decimation_ratio !== 16'd2048) begin errors++; $display("FAIL vec_decim got %0d exp 2048", decimation_ratio); end
    checks++; if (tx_q.size() != 1 || tx_q[0] !== 8'h06) begin errors++; $display("FAIL vec_decim_reply got n=%0d exp one 06", tx_q.size()); end
    tx_q.delete(); e0 = err_cnt;
    make_frame(8'h02, 64'h0001, 8'h00);
    checks++; if (frm[10] !== 8'h03) begin errors++; $display("FAIL vec_decim1_chk got %h exp 03", frm[10]); end
    send_frame(1);
    cyc(6);
    checks++; if (decimation_ratio !== 16'd2048) begin errors++; $display("FAIL vec_decim1 got %0d exp 2048", decimation_ratio); end
    checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL vec_decim1_err got %0d exp 1", err_cnt - e0); end
    checks++; if (tx_q.size() != 1 || tx_q[0] !== 8'h15) begin errors++; $display("FAIL vec_decim1_reply got n=%0d exp one 15", tx_q.size()); end
    exp_phase = 64'h10;
    exp_decim = 16'd2048;
  endtask

  task automatic test_idle_junk();
    int e0;
    e0 = err_cnt; tx_q.delete();
    for (int i = 0; i < 10; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      if (b == 8'hA5) b = 8'h5A;
      send_byte(b, int'($urandom_range(3, 0)));
    end
    cyc(2 * T);
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL idle_junk_err got %0d exp 0", err_cnt - e0); end
    checks++; if (tx_q.size() != 0) begin errors++; $display("FAIL idle_junk_reply got n=%0d exp 0", tx_q.size()); end
  endtask

  task automatic test_timeout();
    int e0, u0;
    bit acc;
    e0 = err_cnt; tx_q.delete();
    send_byte(8'hA5, 1); send_byte(8'h01, 2);
    send_byte(8'h11, 0); send_byte(8'h22, 3); send_byte(8'h33, 0);
    cyc(T + 5);
    checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL timeout_err got %0d exp 1", err_cnt - e0); end
    checks++; if (tx_q.size() != 0) begin errors++; $display("FAIL timeout_reply got n=%0d exp 0", tx_q.size()); end
    cyc(2 * T);
    checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL timeout_idle_count got %0d exp 1", err_cnt - e0); end
    u0 = upd_cnt;
    make_frame(8'h01, {$urandom, $urandom}, 8'h00);
    model_frame(acc);
    send_frame(3);
    cyc(6);
    checks++; if (phase_inc_carr !== exp_phase || upd_cnt - u0 !== 1) begin errors++; $display("FAIL timeout_recover got %h upd=%0d exp %h upd=1", phase_inc_carr, upd_cnt - u0, exp_phase); end
    // A sync byte arriving exactly at expiry is parsed from idle and starts a frame.
    e0 = err_cnt; u0 = upd_cnt; tx_q.delete();
    make_frame(8'h01, {$urandom, $urandom}, 8'h00);
    model_frame(acc);
    send_byte(8'hA5, 0);
    send_byte(8'h01, T);
    for (int i = 0; i < 11; i++) send_byte(frm[i], 0);
    cyc(6);
    checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL timeout_coinc_err got %0d exp 1", err_cnt - e0); end
    checks++; if (phase_inc_carr !== exp_phase || upd_cnt - u0 !== 1) begin errors++; $display("FAIL timeout_coinc_load got %h upd=%0d exp %h", phase_inc_carr, upd_cnt - u0, exp_phase); end
    checks++; if (tx_q.size() != 1 || tx_q[0] !== 8'h06) begin errors++; $display("FAIL timeout_coinc_reply got n=%0d exp one 06", tx_q.size()); end
  endtask

  task automatic test_tx_hold();
    bit acc;
    i_Tx_Active = 1'b1;
    tx_q.delete();
    make_frame(8'h02, {48'($urandom), 16'($urandom_range(65535, 2))}, 8'h00);
    model_frame(acc);
    send_frame(2);
    make_frame(8'h01, {$urandom, $urandom}, 8'h40);
    model_frame(acc);
    send_frame(2);
    cyc(10);
    checks++; if (tx_q.size() != 0) begin errors++; $display("FAIL tx_hold_blocked got n=%0d exp 0", tx_q.size()); end
    i_Tx_Active = 1'b0;
    cyc(8);
    checks++; if (tx_q.size() != 1 || tx_q[0] !== 8'h15) begin errors++; $display("FAIL tx_hold_reply got n=%0d first=%h exp one 15", tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'hxx); end
    checks++; if (decimation_ratio !== exp_decim || phase_inc_carr !== exp_phase) begin errors++; $display("FAIL tx_hold_regs got %h/%h exp %h/%h", decimation_ratio, phase_inc_carr, exp_decim, exp_phase); end
  endtask

  task automatic test_reset_midframe();
    int e0, u0;
    bit acc;
    e0 = err_cnt; tx_q.delete();
    make_frame(8'h01, {$urandom, $urandom}, 8'h00);
    for (int i = 0; i < 6; i++) send_byte(frm[i], 1);
    rst = 1'b1;
    cyc(2);
    checks++; if (phase_inc_carr !== DEF_PH || decimation_ratio !== DEF_DEC) begin errors++; $display("FAIL rst_mid_regs got %h/%h exp defaults", phase_inc_carr, decimation_ratio); end
    rst = 1'b0;
    exp_phase = DEF_PH;
    exp_decim = DEF_DEC;
    cyc(T + 10);
    checks++; if (err_cnt - e0 !== 0 || tx_q.size() != 0) begin errors++; $display("FAIL rst_mid_err got err=%0d tx=%0d exp 0/0", err_cnt - e0, tx_q.size()); end
    u0 = upd_cnt;
    make_frame(8'h02, 64'h1234_5678_9ABC_0040, 8'h00);
    model_frame(acc);
    send_frame(2);
    cyc(6);
    checks++; if (decimation_ratio !== 16'h0040 || upd_cnt - u0 !== 1) begin errors++; $display("FAIL rst_mid_recover got %h upd=%0d exp 0040 upd=1", decimation_ratio, upd_cnt - u0); end
  endtask

  task automatic test_random();
    bit acc;
    int u0, e0;
    logic [7:0]  cmd, flip;
    logic [63:0] pl;
    for (int n = 0; n < 40; n++) begin
      u0 = upd_cnt; e0 = err_cnt; tx_q.delete();
      case ($urandom_range(3, 0))
        0: cmd = 8'h01;
        1, 2: cmd = 8'h02;
        default: cmd = 8'($urandom);
      endcase
      pl = {$urandom, $urandom};
      if ($urandom_range(3, 0) == 0) pl[15:0] = 16'($urandom_range(2, 0));
      if ($urandom_range(2, 0) == 0) pl[39:32] = 8'hA5;
      flip = ($urandom_range(4, 0) == 0) ? 8'(1 << $urandom_range(7, 0)) : 8'h00;
      make_frame(cmd, pl, flip);
      model_frame(acc);
      send_frame(4);
      cyc(6);
      checks++; if (phase_inc_carr !== exp_phase) begin errors++; $display("FAIL rand_phase n=%0d got %h exp %h", n, phase_inc_carr, exp_phase); end
      checks++; if (decimation_ratio !== exp_decim) begin errors++; $display("FAIL rand_decim n=%0d got %h exp %h", n, decimation_ratio, exp_decim); end
      checks++; if (upd_cnt - u0 !== int'(acc) || err_cnt - e0 !== int'(!acc)) begin errors++; $display("FAIL rand_pulses n=%0d got upd=%0d err=%0d exp acc=%0d", n, upd_cnt - u0, err_cnt - e0, acc); end
      checks++; if (tx_q.size() != 1 || tx_q[0] !== (acc ? 8'h06 : 8'h15)) begin errors++; $display("FAIL rand_reply n=%0d got n=%0d first=%h acc=%0d", n, tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'hxx, acc); end
    end
  endtask

  initial begin
    rst         = 1'b1;
    i_Rx_DV     = 1'b0;
    i_Rx_Byte   = 8'h00;
    i_Tx_Active = 1'b0;
    exp_phase   = DEF_PH;
    exp_decim   = DEF_DEC;
    test_reset();
    test_bad_chk();
    test_vectors();
    test_idle_junk();
    test_timeout();
    test_tx_hold();
    test_reset_midframe();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
